drp_rmw_master: RTL and testbench

DRP_RMW_MASTER -- requirements
Module: drp_rmw_master

---
 rtl/drp_rmw_master.sv | 194 +++++++++++++++++++
 tb/tb_drp_rmw_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drp_rmw_master.sv
// DRP master issuing single reads or masked read-modify-writes with per-access timeout.
// Optional read-back verification of the written word: define DRP_RMW_READBACK_VERIFY_EN.
module drp_rmw_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [8:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [15:0] cmd_mask,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        rsp_mismatch,
    output logic        drp_en,
    output logic        drp_we,
    output logic [8:0]  drp_addr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP
`ifdef DRP_RMW_READBACK_VERIFY_EN
        , VF_REQ, VF_WAIT
`endif
    } state_e;

    // Last wait cycle index: the counter starts at 0 in the first wait cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mask_q, mask_d;
    logic        write_q, write_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        timeout_q, timeout_d;
    logic [15:0] wr_value;
    logic        wait_last;

    assign wr_value  = (wdata_q & mask_q) | (rd_q & ~mask_q);
    assign wait_last = (cnt_q == WAIT_LAST);

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign drp_addr    = addr_q;
    assign drp_di      = wr_value;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = timeout_q;

`ifdef DRP_RMW_READBACK_VERIFY_EN
    logic mismatch_q, mismatch_d;
    assign rsp_mismatch = mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        write_d    = write_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        timeout_d  = timeout_q;
`ifdef DRP_RMW_READBACK_VERIFY_EN
        mismatch_d = mismatch_q;
`endif
        drp_en     = 1'b0;
        drp_we     = 1'b0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    mask_d    = cmd_mask;
                    write_d   = cmd_write;
                    rd_d      = 16'h0000;
                    timeout_d = 1'b0;
`ifdef DRP_RMW_READBACK_VERIFY_EN
                    mismatch_d = 1'b0;
`endif
                    // A full-mask write needs nothing from the old value.
                    state_d = (cmd_write && cmd_mask == 16'hFFFF) ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                drp_en  = 1'b1;
                cnt_d   = 16'h0000;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_rdy) begin
                    rd_d    = drp_do;
                    state_d = write_q ? WR_REQ : RESP;
                end else if (wait_last) begin
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WR_REQ: begin
                drp_en  = 1'b1;
                drp_we  = 1'b1;
                cnt_d   = 16'h0000;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (drp_rdy) begin
`ifdef DRP_RMW_READBACK_VERIFY_EN
                    state_d = VF_REQ;
`else
                    state_d = RESP;
`endif
                end else if (wait_last) begin
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef DRP_RMW_READBACK_VERIFY_EN
            VF_REQ: begin
                drp_en  = 1'b1;
                cnt_d   = 16'h0000;
                state_d = VF_WAIT;
            end
            VF_WAIT: begin
                if (drp_rdy) begin
                    if (drp_do != wr_value) mismatch_d = 1'b1;
                    state_d = RESP;
                end else if (wait_last) begin
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Publish the original read value in the same cycle rsp_valid rises.
        if (state_d == RESP) rsp_data_d = rd_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 16'h0000;
            addr_q     <= 9'h000;
            wdata_q    <= 16'h0000;
            mask_q     <= 16'h0000;
            write_q    <= 1'b0;
            rd_q       <= 16'h0000;
            rsp_data_q <= 16'h0000;
            timeout_q  <= 1'b0;
`ifdef DRP_RMW_READBACK_VERIFY_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            write_q    <= write_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            timeout_q  <= timeout_d;
`ifdef DRP_RMW_READBACK_VERIFY_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

endmodule

// File: tb/tb_drp_rmw_master.sv
// Directed bench for drp_rmw_master with a behavioural DRP slave of configurable ready delay.
// Latencies count the accept cycle as cycle 1 (zero-wait read-only -> 4, RMW -> 6).
module tb_drp_rmw_master;

`ifdef DRP_RMW_READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [8:0]  cmd_addr = 9'h000;
    logic [15:0] cmd_wdata = 16'h0000;
    logic [15:0] cmd_mask = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        rsp_mismatch;
    logic        drp_en;
    logic        drp_we;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_rdy = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    drp_rmw_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .rsp_mismatch(rsp_mismatch),
        .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_rdy(drp_rdy)
    );

    always #5 clk = ~clk;

    // DRP slave model: answers each strobe after rdy_delay cycles unless drp_dead.
    int          rdy_delay = 1;
    bit          drp_dead = 1'b0;
    logic [15:0] rd_value = 16'h0000;
    logic [15:0] vf_value = 16'h0000;
    int          pend_cnt = 0;
    logic [15:0] pend_data = 16'h0000;
    int          en_cnt = 0, rd_cnt = 0, we_cnt = 0, viol_cnt = 0;
    logic [15:0] last_di = 16'h0000;
    logic [8:0]  last_rd_addr = 9'h000, last_wr_addr = 9'h000, hold_addr = 9'h000;
    logic [15:0] hold_di = 16'h0000;
    bit          hold_we = 1'b0, outstanding = 1'b0, wrote = 1'b0;

    always @(negedge clk) begin
        drp_rdy = 1'b0;
        if (outstanding && (drp_addr !== hold_addr || (hold_we && drp_di !== hold_di)))
            viol_cnt++;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                drp_rdy = 1'b1;
                drp_do = pend_data;
                outstanding = 1'b0;
            end
        end
        if (rsp_valid) begin
            outstanding = 1'b0;
            wrote = 1'b0;
        end
        if (drp_en) begin
            if (outstanding) viol_cnt++;
            en_cnt++;
            if (drp_we) begin
                we_cnt++;
                last_di = drp_di;
                last_wr_addr = drp_addr;
                pend_data = 16'h0000;
                wrote = 1'b1;
            end else begin
                rd_cnt++;
                last_rd_addr = drp_addr;
                pend_data = wrote ? vf_value : rd_value;
            end
            hold_addr = drp_addr;
            hold_di = drp_di;
            hold_we = drp_we;
            outstanding = 1'b1;
            if (!drp_dead) pend_cnt = rdy_delay;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one command starting at a negedge; returns at the negedge of the response cycle.
    task automatic send_cmd(input logic wr, input logic [8:0] a, input logic [15:0] wd,
                            input logic [15:0] m, output int waited, output int lat,
                            output bit got, output logic [15:0] data, output logic to,
                            output logic mm);
        int k;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_mask  = m;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        got  = rsp_valid;
        lat  = k + 1;
        data = rsp_data;
        to   = rsp_timeout;
        mm   = rsp_mismatch;
    endtask

    task automatic test_reset();
        int en0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if ({cmd_ready, rsp_valid, drp_en, drp_we, rsp_timeout, rsp_mismatch} !== 6'b100000) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected %b", {cmd_ready, rsp_valid, drp_en, drp_we, rsp_timeout, rsp_mismatch}, 6'b100000); end
        tests_run++; if ({rsp_data, drp_addr, drp_di} !== 41'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {rsp_data, drp_addr, drp_di}); end
        // Command presented while reset is high must be dropped.
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 9'h1AB;
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0;
        en0 = en_cnt;
        repeat (4) @(negedge clk);
        tests_run++; if (en_cnt - en0 !== 0) begin tests_failed++; $display("FAIL reset_cmd_dropped: got %0d strobes expected 0", en_cnt - en0); end
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_read_only();
        int w, lat, rd0, we0, v0;
        bit got;
        logic [15:0] data;
        logic to, mm;
        rdy_delay = 2;
        rd_value = 16'hA5A5;
        vf_value = 16'hA5A5;
        rd0 = rd_cnt; we0 = we_cnt; v0 = viol_cnt;
        send_cmd(1'b0, 9'h03D, 16'hFFFF, 16'h0000, w, lat, got, data, to, mm);
        tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL ro_rsp: got %b expected 1", got); end
        tests_run++; if (data !== 16'hA5A5) begin tests_failed++; $display("FAIL ro_data: got %h expected a5a5", data); end
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL ro_timeout: got %b expected 0", to); end
        tests_run++; if (rd_cnt - rd0 !== 1 || we_cnt - we0 !== 0) begin tests_failed++; $display("FAIL ro_strobes: got rd=%0d we=%0d expected rd=1 we=0", rd_cnt - rd0, we_cnt - we0); end
        tests_run++; if (last_rd_addr !== 9'h03D) begin tests_failed++; $display("FAIL ro_addr: got %h expected 03d", last_rd_addr); end
        tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL ro_latency: got %0d expected 5", lat); end
        tests_run++; if (viol_cnt - v0 !== 0) begin tests_failed++; $display("FAIL ro_protocol: got %0d violations expected 0", viol_cnt - v0); end
        repeat (2) @(negedge clk);
        tests_run++; if (rsp_data !== 16'hA5A5 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ro_hold: got data=%h valid=%b expected a5a5/0", rsp_data, rsp_valid); end
    endtask

    task automatic test_latency();
        int w, lat;
        bit got;
        logic [15:0] data;
        logic to, mm;
        rdy_delay = 1;
        rd_value = 16'h0F0F;
        vf_value = 16'h0F0F;
        send_cmd(1'b0, 9'h001, 16'h0000, 16'h0000, w, lat, got, data, to, mm);
        tests_run++; if (lat !== 4 || data !== 16'h0F0F) begin tests_failed++; $display("FAIL lat_read: got lat=%0d data=%h expected 4/0f0f", lat, data); end
        @(negedge clk);
        rd_value = 16'h5555;
        vf_value = 16'h5A5A;
        send_cmd(1'b1, 9'h010, 16'hAAAA, 16'h0F0F, w, lat, got, data, to, mm);
        tests_run++; if (lat !== (VERIFY ? 8 : 6)) begin tests_failed++; $display("FAIL lat_rmw: got %0d expected %0d", lat, VERIFY ? 8 : 6); end
        tests_run++; if (last_di !== 16'h5A5A || data !== 16'h5555 || mm !== 1'b0) begin tests_failed++; $display("FAIL lat_rmw_data: got di=%h data=%h mm=%b expected 5a5a/5555/0", last_di, data, mm); end
    endtask

    task automatic test_rmw();
        int w, lat, rd0, we0, v0;
        bit got;
        logic [15:0] data;
        logic to, mm;
        @(negedge clk);
        rdy_delay = 2;
        rd_value = 16'h1234;
        vf_value = 16'h12F0;
        rd0 = rd_cnt; we0 = we_cnt; v0 = viol_cnt;
        send_cmd(1'b1, 9'h082, 16'h00F0, 16'h00FF, w, lat, got, data, to, mm);
        tests_run++; if (last_di !== 16'h12F0) begin tests_failed++; $display("FAIL rmw_di: got %h expected 12f0", last_di); end
        tests_run++; if (last_wr_addr !== 9'h082) begin tests_failed++; $display("FAIL rmw_wr_addr: got %h expected 082", last_wr_addr); end
        tests_run++; if (data !== 16'h1234 || to !== 1'b0 || mm !== 1'b0) begin tests_failed++; $display("FAIL rmw_rsp: got data=%h to=%b mm=%b expected 1234/0/0", data, to, mm); end
        tests_run++; if (we_cnt - we0 !== 1 || rd_cnt - rd0 !== (VERIFY ? 2 : 1)) begin tests_failed++; $display("FAIL rmw_strobes: got rd=%0d we=%0d expected rd=%0d we=1", rd_cnt - rd0, we_cnt - we0, VERIFY ? 2 : 1); end
        tests_run++; if (lat !== (VERIFY ? 11 : 8)) begin tests_failed++; $display("FAIL rmw_latency: got %0d expected %0d", lat, VERIFY ? 11 : 8); end
        tests_run++; if (viol_cnt - v0 !== 0) begin tests_failed++; $display("FAIL rmw_protocol: got %0d violations expected 0", viol_cnt - v0); end
    endtask

    task automatic test_full_mask();
        int w, lat, rd0, we0;
        bit got;
        logic [15:0] data;
        logic to, mm;
        @(negedge clk);
        rdy_delay = 1;
        rd_value = 16'h7777;
        vf_value = 16'hBEEF;
        rd0 = rd_cnt; we0 = we_cnt;
        send_cmd(1'b1, 9'h1FF, 16'hBEEF, 16'hFFFF, w, lat, got, data, to, mm);
        tests_run++; if (rd_cnt - rd0 !== (VERIFY ? 1 : 0) || we_cnt - we0 !== 1) begin tests_failed++; $display("FAIL full_strobes: got rd=%0d we=%0d expected rd=%0d we=1", rd_cnt - rd0, we_cnt - we0, VERIFY ? 1 : 0); end
        tests_run++; if (last_di !== 16'hBEEF || last_wr_addr !== 9'h1FF) begin tests_failed++; $display("FAIL full_di: got %h@%h expected beef@1ff", last_di, last_wr_addr); end
        tests_run++; if (data !== 16'h0000) begin tests_failed++; $display("FAIL full_data: got %h expected 0000", data); end
        tests_run++; if (lat !== (VERIFY ? 6 : 4)) begin tests_failed++; $display("FAIL full_latency: got %0d expected %0d", lat, VERIFY ? 6 : 4); end
    endtask

    task automatic test_verify();
        int w, lat;
        bit got;
        logic [15:0] data;
        logic to, mm;
        @(negedge clk);
        rdy_delay = 1;
        rd_value = 16'h1234;
        vf_value = 16'h12F1;
        send_cmd(1'b1, 9'h082, 16'h00F0, 16'h00FF, w, lat, got, data, to, mm);
        tests_run++; if (mm !== VERIFY) begin tests_failed++; $display("FAIL vf_mismatch: got %b expected %b", mm, VERIFY); end
        tests_run++; if (last_di !== 16'h12F0 || data !== 16'h1234) begin tests_failed++; $display("FAIL vf_data: got di=%h data=%h expected 12f0/1234", last_di, data); end
    endtask

    // Starts in the response cycle of the previous command.
    task automatic test_back_to_back();
        int w, lat;
        bit got;
        logic [15:0] data;
        logic to, mm;
        rd_value = 16'h1111;
        vf_value = 16'h1111;
        send_cmd(1'b0, 9'h0AA, 16'h0000, 16'h0000, w, lat, got, data, to, mm);
        tests_run++; if (w !== 1) begin tests_failed++; $display("FAIL b2b_accept1: got wait=%0d expected 1", w); end
        tests_run++; if (data !== 16'h1111 || mm !== 1'b0) begin tests_failed++; $display("FAIL b2b_rsp1: got data=%h mm=%b expected 1111/0", data, mm); end
        rd_value = 16'h2222;
        vf_value = 16'h222F;
        send_cmd(1'b1, 9'h0AB, 16'h00FF, 16'h000F, w, lat, got, data, to, mm);
        tests_run++; if (w !== 1) begin tests_failed++; $display("FAIL b2b_accept2: got wait=%0d expected 1", w); end
        tests_run++; if (last_di !== 16'h222F || data !== 16'h2222) begin tests_failed++; $display("FAIL b2b_rsp2: got di=%h data=%h expected 222f/2222", last_di, data); end
    endtask

    task automatic test_timeout();
        int w, lat, en0, we0, v0;
        bit got;
        logic [15:0] data;
        logic to, mm;
        @(negedge clk);
        drp_dead = 1'b1;
        en0 = en_cnt; we0 = we_cnt; v0 = viol_cnt;
        send_cmd(1'b1, 9'h055, 16'h1234, 16'h00FF, w, lat, got, data, to, mm);
        tests_run++; if (got !== 1'b1 || to !== 1'b1) begin tests_failed++; $display("FAIL to_flag: got valid=%b timeout=%b expected 1/1", got, to); end
        tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL to_latency: got %0d expected 11", lat); end
        tests_run++; if (en_cnt - en0 !== 1 || we_cnt - we0 !== 0) begin tests_failed++; $display("FAIL to_strobes: got en=%0d we=%0d expected en=1 we=0", en_cnt - en0, we_cnt - we0); end
        tests_run++; if (data !== 16'h0000 || viol_cnt - v0 !== 0) begin tests_failed++; $display("FAIL to_data: got data=%h viol=%0d expected 0000/0", data, viol_cnt - v0); end
        drp_dead = 1'b0;
        rdy_delay = 1;
        rd_value = 16'h3C3C;
        vf_value = 16'h3C3C;
        send_cmd(1'b0, 9'h056, 16'h0000, 16'h0000, w, lat, got, data, to, mm);
        tests_run++; if (to !== 1'b0 || data !== 16'h3C3C || lat !== 4) begin tests_failed++; $display("FAIL to_recover: got to=%b data=%h lat=%0d expected 0/3c3c/4", to, data, lat); end
    endtask

    task automatic test_reset_midflight();
        int w, lat, en0, rsp_seen, not_ready;
        bit got;
        logic [15:0] data;
        logic to, mm;
        @(negedge clk);
        rdy_delay = 2;
        rd_value = 16'hDEAD;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 9'h0C3;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++; if (drp_en !== 1'b1 || drp_we !== 1'b0) begin tests_failed++; $display("FAIL mid_rd_req: got en=%b we=%b expected 1/0", drp_en, drp_we); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        en0 = en_cnt;
        rsp_seen = 0;
        not_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            if (!cmd_ready) not_ready++;
        end
        tests_run++; if (rsp_seen !== 0 || en_cnt - en0 !== 0) begin tests_failed++; $display("FAIL mid_late_rdy: got rsp=%0d en=%0d expected 0/0", rsp_seen, en_cnt - en0); end
        tests_run++; if (not_ready !== 0) begin tests_failed++; $display("FAIL mid_ready: got %0d idle-not-ready cycles expected 0", not_ready); end
        tests_run++; if (rsp_data !== 16'h0000 || rsp_timeout !== 1'b0) begin tests_failed++; $display("FAIL mid_outputs: got data=%h to=%b expected 0000/0", rsp_data, rsp_timeout); end
        rdy_delay = 1;
        rd_value = 16'h4321;
        vf_value = 16'h4321;
        send_cmd(1'b0, 9'h0C4, 16'h0000, 16'h0000, w, lat, got, data, to, mm);
        tests_run++; if (data !== 16'h4321 || lat !== 4) begin tests_failed++; $display("FAIL mid_after: got data=%h lat=%0d expected 4321/4", data, lat); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read_only();
        test_latency();
        test_rmw();
        test_full_mask();
        test_verify();
        test_back_to_back();
        test_timeout();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
